// File: rtl/multi_hex_display.sv
// multi_hex_display
//   Drives DIGITS seven-segment digits (active-low) from a captured binary
//   value. Values are shown either in hexadecimal (shown on the next edge) or
//   in decimal (converted by a sequential double-dabble over WIDTH cycles).
//   Leading zeros can be blanked. A value that does not fit shows dashes.
//   The whole display can be flashed with a free-running blink divider.
//
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   value     in   [WIDTH-1:0] unsigned number to display
//   load      in   capture value/dec_mode/blank_lz (accepted only when ready)
//   dec_mode  in   1 = decimal, 0 = hexadecimal
//   blank_lz  in   1 = blank leading-zero digits
//   blink     in   1 = flash display (live, not captured)
//   ready     out  high in IDLE, i.e. when a load would be accepted
//   hex       out  [7*DIGITS-1:0] active-low segments, digit i at [7i+6:7i]
module multi_hex_display #(
  parameter int DIGITS    = 6,
  parameter int WIDTH     = 20,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  input  logic                  dec_mode,
  input  logic                  blank_lz,
  input  logic                  blink,
  output logic                  ready,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Largest value representable in DIGITS decimal digits.
  function automatic logic [63:0] dec_max(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r - 64'd1;
  endfunction
  localparam logic [63:0] DEC_MAX = dec_max(DIGITS);

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     val_q, val_d;      // captured value; shifted out during CONVERT
  logic                 dec_q, dec_d;
  logic                 blz_q, blz_d;
  logic                 ovf_q, ovf_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7*DIGITS-1:0]  hex_q, hex_d;
  logic [BLK_W-1:0]     blk_cnt_q, blk_cnt_d;
  logic                 phase_q, phase_d;

  logic [63:0]          value_ext;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     disp_src;
  logic [7*DIGITS-1:0]  digits;
  logic                 leading;
  logic [3:0]           nib;

  assign value_ext = 64'(value);

  // Double-dabble correction: each BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Segment patterns for the captured operand. Leading-zero blanking walks
  // from the most significant digit down until the first nonzero nibble;
  // digit 0 always shows, so zero displays as a single "0".
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    digits   = '1;
    leading  = 1'b1;
    nib      = '0;
    disp_src = dec_q ? bcd_q : BCD_W'(val_q);
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = disp_src[4*i +: 4];
      if (ovf_q) begin
        digits[7*i +: 7] = SEG_DASH;
      end else if (blz_q && leading && nib == 4'd0 && i != 0) begin
        digits[7*i +: 7] = SEG_BLANK;
      end else begin
        digits[7*i +: 7] = seg7(nib);
        leading          = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    dec_d     = dec_q;
    blz_d     = blz_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    hex_d     = hex_q;
    blk_cnt_d = blk_cnt_q + BLK_W'(1);
    phase_d   = phase_q;

    if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          val_d   = value;
          dec_d   = dec_mode;
          blz_d   = blank_lz;
          bcd_d   = '0;
          cnt_d   = '0;
          // Overflow is judged once, on the raw captured value.
          ovf_d   = dec_mode ? (value_ext > DEC_MAX) : ((value_ext >> BCD_W) != 64'd0);
          state_d = dec_mode ? CONVERT : UPDATE;
        end
      end
      CONVERT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], val_q[WIDTH-1]};
        val_d = val_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        hex_d   = digits;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      val_q     <= '0;
      dec_q     <= 1'b0;
      blz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      hex_q     <= '1;
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q   <= state_d;
      val_q     <= val_d;
      dec_q     <= dec_d;
      blz_q     <= blz_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      hex_q     <= hex_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign ready = (state_q == IDLE);
  // Blink overrides the output only; registered digits and FSM are untouched.
  assign hex   = (blink && phase_q) ? '1 : hex_q;

endmodule

// File: tb/tb_multi_hex_display.sv
// Testbench for multi_hex_display (DIGITS=6, WIDTH=20, BLINK_DIV=4).
// Stimulus pushes the hand-computed expected display into a scoreboard queue
// when it issues a load; a monitor pops and compares each time ready rises.
module tb_multi_hex_display;

  localparam int DIGITS = 6;
  localparam int WIDTH  = 20;
  localparam int HW     = 7 * DIGITS;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011,
                         SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110,
                         BL = 7'b1111111, DA = 7'b0111111;

  localparam logic [HW-1:0] ALL_BLANK = {BL, BL, BL, BL, BL, BL};
  localparam logic [HW-1:0] ALL_DASH  = {DA, DA, DA, DA, DA, DA};
  localparam logic [HW-1:0] D_12345   = {S0, S1, S2, S3, S4, S5};

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] value = '0;
  logic             load = 1'b0;
  logic             dec_mode = 1'b0;
  logic             blank_lz = 1'b0;
  logic             blink = 1'b0;
  logic             ready;
  logic [HW-1:0]    hex;

  int checks   = 0;
  int failures = 0;
  logic [HW-1:0] sb_q[$];

  multi_hex_display #(.DIGITS(DIGITS), .WIDTH(WIDTH), .BLINK_DIV(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value    (value),
    .load     (load),
    .dec_mode (dec_mode),
    .blank_lz (blank_lz),
    .blink    (blink),
    .ready    (ready),
    .hex      (hex)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: a rising ready (outside reset) marks a completed update.
  initial begin
    logic          ready_prev;
    logic [HW-1:0] exp;
    ready_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n && ready && !ready_prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_update", 64'(hex), 64'(ALL_BLANK));
        end else begin
          exp = sb_q.pop_front();
          check("display", 64'(hex), 64'(exp));
        end
      end
      ready_prev = ready;
    end
  end

  task automatic issue(input logic [WIDTH-1:0] v, input logic dm, input logic blz);
    @(negedge clk);
    value    = v;
    dec_mode = dm;
    blank_lz = blz;
    load     = 1'b1;
  endtask

  // Counts negedges with ready low until ready returns (bounded).
  task automatic wait_done(input string name, input int exp_busy);
    int busy;
    busy = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ready) break;
      busy++;
    end
    check(name, 64'(busy), 64'(exp_busy));
  endtask

  task automatic txn(input string name, input logic [WIDTH-1:0] v, input logic dm,
                     input logic blz, input logic [HW-1:0] exp, input int exp_busy);
    issue(v, dm, blz);
    sb_q.push_back(exp);
    @(posedge clk);
    #1 load = 1'b0;
    wait_done(name, exp_busy);
  endtask

  initial begin
    logic [HW-1:0] prev, cur, other;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_hex", 64'(hex), 64'(ALL_BLANK));
    check("reset_ready", 64'(ready), 64'd1);
    reset_n = 1'b1;

    txn("busy_hex_abcde", 20'hABCDE, 1'b0, 1'b0, {S0, SA, SB, SC, SD, SE}, 1);
    txn("busy_dec_12345", 20'd12345, 1'b1, 1'b1, {BL, S1, S2, S3, S4, S5}, 21);
    txn("busy_dec_ovf",   20'd1048575, 1'b1, 1'b1, ALL_DASH, 21);
    txn("busy_hex_zero",  20'd0, 1'b0, 1'b1, {BL, BL, BL, BL, BL, S0}, 1);
    txn("busy_dec_max",   20'd999999, 1'b1, 1'b0, {S9, S9, S9, S9, S9, S9}, 21);
    txn("busy_dec_1m",    20'd1000000, 1'b1, 1'b0, ALL_DASH, 21);

    // Load during conversion is ignored
    issue(20'd12345, 1'b1, 1'b0);
    sb_q.push_back(D_12345);
    @(posedge clk);                 // T0
    #1 load = 1'b0;
    repeat (4) @(posedge clk);      // T0+4
    #1;
    value    = 20'd777;
    dec_mode = 1'b0;
    load     = 1'b1;
    @(posedge clk);                 // T0+5
    #1 load = 1'b0;
    wait_done("busy_ignore_777", 16);

    // Blink: output alternates blank/digits every 4 cycles
    blink = 1'b1;
    @(negedge clk);
    prev = hex;
    cur  = hex;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      cur = hex;
      if (cur != prev) break;
      prev = cur;
    end
    check("blink_toggle_seen", 64'(cur != prev), 64'd1);
    check("blink_value_legal", 64'(cur == ALL_BLANK || cur == D_12345), 64'd1);
    other = (cur == ALL_BLANK) ? D_12345 : ALL_BLANK;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("blink_hold", 64'(hex), 64'(cur));
    end
    @(negedge clk);
    check("blink_flip", 64'(hex), 64'(other));
    blink = 1'b0;
    #1 check("blink_off", 64'(hex), 64'(D_12345));

    // Reset aborts a conversion; no partial result reaches hex
    issue(20'd12345, 1'b1, 1'b1);
    @(posedge clk);                 // T0
    #1 load = 1'b0;
    repeat (10) @(posedge clk);     // T0+10
    #1 reset_n = 1'b0;
    #1;
    check("abort_hex", 64'(hex), 64'(ALL_BLANK));
    check("abort_ready", 64'(ready), 64'd1);
    repeat (2) @(negedge clk);
    check("abort_hold_hex", 64'(hex), 64'(ALL_BLANK));

    // Load on the first edge after reset release
    reset_n  = 1'b1;
    value    = 20'd42;
    dec_mode = 1'b0;
    blank_lz = 1'b0;
    load     = 1'b1;
    sb_q.push_back({S0, S0, S0, S0, S2, SA});
    @(posedge clk);
    #1 load = 1'b0;
    wait_done("busy_after_reset", 1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
